// File: rtl/fpu_issue_sched.sv
// Single-outstanding issue scheduler for the multi-cycle FPU datapath.
// Optional perf counters are enabled by defining FPU_SCHED_PERF_EN.
module fpu_issue_sched #(
    parameter int unsigned LAT_ADD  = 5,
    parameter int unsigned LAT_MUL  = 5,
    parameter int unsigned LAT_DIV  = 7,
    parameter int unsigned LAT_SQRT = 3,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_cont,
    input  logic [31:0] issue_x1,
    input  logic [31:0] issue_x2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_float,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    output logic [4:0]  fpu_cont,
    input  logic [31:0] fpu_y,
    output logic        busy,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_rd_float,
    output logic [31:0] wb_data,
    input  logic        flush,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic        chk_rs1_float,
    input  logic        chk_rs2_float,
    output logic        hazard
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0] perf_busy_cycles,
    output logic [31:0] perf_hazard_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] x1_q, x1_d;
    logic [31:0] x2_q, x2_d;
    logic [4:0]  cont_q, cont_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_float_q, rd_float_d;
    logic [31:0] data_q, data_d;
    logic        accept;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        rd_live;

    function automatic logic [3:0] lat_of(input logic [4:0] c);
        logic [3:0] l;
        case (c)
            5'b10000, 5'b10001: l = 4'(LAT_ADD);
            5'b10010:           l = 4'(LAT_MUL);
            5'b10011:           l = 4'(LAT_DIV);
            5'b10100:           l = 4'(LAT_SQRT);
            5'b11100, 5'b11101: l = 4'(LAT_CVT);
            default:            l = 4'd0;
        endcase
        return l;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        cont_d      = cont_q;
        rd_d        = rd_q;
        rd_float_d  = rd_float_q;
        data_d      = data_q;
        issue_ready = 1'b0;
        unique case (state_q)
            S_IDLE: issue_ready = !flush;
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    data_d  = fpu_y;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d     = S_IDLE;
                    issue_ready = !flush;
                end
            end
            default: state_d = S_IDLE;
        endcase
        accept = issue_valid && issue_ready;
        if (accept) begin
            x1_d       = issue_x1;
            x2_d       = issue_x2;
            cont_d     = issue_cont;
            rd_d       = issue_rd;
            rd_float_d = issue_rd_float;
            cnt_d      = lat_of(issue_cont);
            state_d    = S_EXEC;
        end
        // Kill wins over everything, including a same-cycle capture.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            x1_q       <= 32'd0;
            x2_q       <= 32'd0;
            cont_q     <= 5'd0;
            rd_q       <= 5'd0;
            rd_float_q <= 1'b0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            cont_q     <= cont_d;
            rd_q       <= rd_d;
            rd_float_q <= rd_float_d;
            data_q     <= data_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign wb_valid    = (state_q == S_WB);
    assign wb_rd       = rd_q;
    assign wb_rd_float = rd_float_q;
    assign wb_data     = data_q;
    assign fpu_x1      = x1_q;
    assign fpu_x2      = x2_q;
    assign fpu_cont    = (state_q == S_EXEC) ? cont_q : 5'd0;

    // Integer x0 is never a real dependency.
    assign rd_live = (rd_q != 5'd0) || rd_float_q;
    assign rs1_hit = (chk_rs1 == rd_q) && (chk_rs1_float == rd_float_q);
    assign rs2_hit = (chk_rs2 == rd_q) && (chk_rs2_float == rd_float_q);
    assign hazard  = busy && rd_live && (rs1_hit || rs2_hit);

`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_haz_q, perf_haz_d;

    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_haz_d  = perf_haz_q;
        if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if (hazard && (perf_haz_q != 32'hFFFF_FFFF)) begin
            perf_haz_d = perf_haz_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_busy_q <= 32'd0;
            perf_haz_q  <= 32'd0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_haz_q  <= perf_haz_d;
        end
    end

    assign perf_busy_cycles   = perf_busy_q;
    assign perf_hazard_cycles = perf_haz_q;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Scoreboard bench for fpu_issue_sched: op-level model predicts handshakes
// and writebacks; a negedge monitor pops expected results on each writeback.
module tb_fpu_issue_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_cont;
    logic [31:0] issue_x1;
    logic [31:0] issue_x2;
    logic [4:0]  issue_rd;
    logic        issue_rd_float;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic [4:0]  fpu_cont;
    logic [31:0] fpu_y;
    logic        busy;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic        wb_rd_float;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_rs1_float;
    logic        chk_rs2_float;
    logic        hazard;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_hazard_cycles;
`endif

    fpu_issue_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_cont     (issue_cont),
        .issue_x1       (issue_x1),
        .issue_x2       (issue_x2),
        .issue_rd       (issue_rd),
        .issue_rd_float (issue_rd_float),
        .fpu_x1         (fpu_x1),
        .fpu_x2         (fpu_x2),
        .fpu_cont       (fpu_cont),
        .fpu_y          (fpu_y),
        .busy           (busy),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd          (wb_rd),
        .wb_rd_float    (wb_rd_float),
        .wb_data        (wb_data),
        .flush          (flush),
        .chk_rs1        (chk_rs1),
        .chk_rs2        (chk_rs2),
        .chk_rs1_float  (chk_rs1_float),
        .chk_rs2_float  (chk_rs2_float),
`ifdef FPU_SCHED_PERF_EN
        .perf_busy_cycles   (perf_busy_cycles),
        .perf_hazard_cycles (perf_hazard_cycles),
`endif
        .hazard         (hazard)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // FPU stand-in: result depends on held operands and on the cycle,
    // so a capture on the wrong edge or with unstable operands shows up.
    function automatic logic [31:0] fy(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [4:0] c);
        return a ^ {b[15:0], b[31:16]} ^ {c, 27'd0} ^ 32'h5A5A_0000;
    endfunction

    assign fpu_y = fy(fpu_x1, fpu_x2, fpu_cont) ^ cyc;

    function automatic int lat(input logic [4:0] c);
        if (c == 5'b10000 || c == 5'b10001) return 5;
        if (c == 5'b10010) return 5;
        if (c == 5'b10011) return 7;
        if (c == 5'b10100) return 3;
        if (c == 5'b11100 || c == 5'b11101) return 2;
        return 0;
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rdf;
    } wb_t;

    wb_t q[$];

    int errors = 0;
    int checks = 0;

    bit          m_pend = 1'b0;
    logic [31:0] m_ready;
    logic [31:0] m_x1;
    logic [31:0] m_x2;
    logic [4:0]  m_cont;
    logic [4:0]  m_rd;
    logic        m_rdf;
    logic [31:0] m_pb = 32'd0;
    logic [31:0] m_ph = 32'd0;

    localparam logic [4:0] CODES [11] = '{
        5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101,
        5'b11000, 5'b11100, 5'b11101, 5'b00000, 5'b11111
    };

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit exp_wbv();
        return m_pend && (cyc >= m_ready);
    endfunction

    function automatic bit exp_haz();
        bit h1;
        bit h2;
        h1 = (chk_rs1 == m_rd) && (chk_rs1_float == m_rdf);
        h2 = (chk_rs2 == m_rd) && (chk_rs2_float == m_rdf);
        return m_pend && !(m_rd == 5'd0 && !m_rdf) && (h1 || h2);
    endfunction

    task automatic check_outputs();
        bit v;
        v = exp_wbv();
        chk("issue_ready", issue_ready,
            !flush && (!m_pend || (v && wb_ready)));
        chk("busy", busy, m_pend);
        chk("wb_valid", wb_valid, v);
        chk("hazard", hazard, exp_haz());
        if (m_pend && !v) begin
            chk("fpu_cont", fpu_cont, m_cont);
            chk("fpu_x1", fpu_x1, m_x1);
            chk("fpu_x2", fpu_x2, m_x2);
        end else begin
            chk("fpu_cont_idle", fpu_cont, 5'd0);
        end
`ifdef FPU_SCHED_PERF_EN
        chk("perf_busy", perf_busy_cycles, m_pb);
        chk("perf_hazard", perf_hazard_cycles, m_ph);
`endif
    endtask

    task automatic model_update();
        bit  v;
        wb_t e;
        int  l;
        v = exp_wbv();
        if (m_pend) m_pb++;
        if (exp_haz()) m_ph++;
        if (flush) begin
            if (m_pend) void'(q.pop_back());
            m_pend = 1'b0;
        end else begin
            if (v && wb_ready) m_pend = 1'b0;
            if (issue_valid && !m_pend) begin
                l       = lat(issue_cont);
                e.data  = fy(issue_x1, issue_x2, issue_cont)
                          ^ (cyc + 32'(l) + 32'd1);
                e.rd    = issue_rd;
                e.rdf   = issue_rd_float;
                q.push_back(e);
                m_pend  = 1'b1;
                m_ready = cyc + 32'(l) + 32'd2;
                m_x1    = issue_x1;
                m_x2    = issue_x2;
                m_cont  = issue_cont;
                m_rd    = issue_rd;
                m_rdf   = issue_rd_float;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [4:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rdf,
                          input logic wbr, input logic fl);
        issue_valid    = iv;
        issue_cont     = c;
        issue_x1       = a;
        issue_x2       = b;
        issue_rd       = rd;
        issue_rd_float = rdf;
        wb_ready       = wbr;
        flush          = fl;
    endtask

    task automatic idle(input int n, input logic wbr);
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, wbr, 1'b0);
        repeat (n) tick();
    endtask

    task automatic rand_in();
        logic fl;
        fl = ($urandom_range(0, 19) == 0);
        set_in($urandom_range(0, 9) < 6, CODES[$urandom_range(0, 10)],
               $urandom, $urandom, 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               fl ? 1'b0 : 1'($urandom_range(0, 1)), fl);
        chk_rs1       = 5'($urandom_range(0, 3));
        chk_rs2       = 5'($urandom_range(0, 3));
        chk_rs1_float = 1'($urandom_range(0, 1));
        chk_rs2_float = 1'($urandom_range(0, 1));
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fpu_cont", fpu_cont, 5'd0);
`ifdef FPU_SCHED_PERF_EN
        chk("rst_perf_busy", perf_busy_cycles, 32'd0);
        chk("rst_perf_hazard", perf_hazard_cycles, 32'd0);
`endif
        m_pend = 1'b0;
        m_pb   = 32'd0;
        m_ph   = 32'd0;
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Writeback monitor: every handshake must match the oldest expectation.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rstn && wb_valid && wb_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_spurious: got rd %0d data %h expected none",
                             wb_rd, wb_data);
                end else begin
                    e = q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_rd_float", wb_rd_float, e.rdf);
                end
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        chk_rs1       = 5'd0;
        chk_rs2       = 5'd0;
        chk_rs1_float = 1'b0;
        chk_rs2_float = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue_ready", issue_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_fpu_cont", fpu_cont, 5'd0);
        chk("reset_fpu_x1", fpu_x1, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_hazard", hazard, 1'b0);
        rstn = 1'b1;

        // fmul
        set_in(1'b1, 5'b10010, 32'h3f800000, 32'h40000000, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);
        // feq, zero latency
        set_in(1'b1, 5'b10111, $urandom, $urandom, 5'd5, 1'b0, 1'b1, 1'b0);
        tick();
        idle(3, 1'b1);
        // fdiv to f3 under backpressure, with hazard probes
        set_in(1'b1, 5'b10011, $urandom, $urandom, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_rs1       = 5'd3;
        chk_rs1_float = 1'b1;
        idle(5, 1'b0);
        chk_rs1_float = 1'b0;
        idle(7, 1'b0);
        // fadd accepted on the same edge as the fdiv writeback
        set_in(1'b1, 5'b10000, $urandom, $urandom, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);
        // fcvt.w.s to integer x0
        chk_rs2       = 5'd0;
        chk_rs2_float = 1'b0;
        set_in(1'b1, 5'b11101, $urandom, $urandom, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        idle(5, 1'b1);
        // fsqrt flushed mid-exec with a competing issue, then re-issue
        set_in(1'b1, 5'b10100, $urandom, $urandom, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        idle(1, 1'b0);
        set_in(1'b1, 5'b10000, $urandom, $urandom, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 5'b10001, $urandom, $urandom, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        idle(8, 1'b1);
        // async reset while the result waits in writeback
        set_in(1'b1, 5'b10111, $urandom, $urandom, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        idle(2, 1'b0);
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        async_reset();
        idle(2, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            rand_in();
            tick();
        end
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
